// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the RISC-V core.
//
// Keeps the fetch PC and issues single-outstanding requests to instruction
// memory. Returned words are buffered with their PC in a small prefetch
// FIFO. The FIFO head is presented combinationally to control_logic, or an
// all-zero bubble when nothing is buffered. A taken branch or jump on
// pc_sel_i redirects the fetch PC and flushes the FIFO.
//
// Parameters
//   RESET_PC    fetch PC loaded on reset, bits [1:0] must be 0
//   FIFO_DEPTH  prefetch FIFO entries, power of 2, >= 2
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   pc_sel_i        redirect request
//   target_i        redirect target (low two bits ignored)
//   stall_i         downstream hold: keep the FIFO head
//   imem_req_o      memory request valid
//   imem_addr_o     memory request byte address (word aligned)
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   response data valid
//   imem_rdata_i    response instruction word
//   inst_o, pc_o    FIFO head instruction and its PC (zero when empty)
//   inst_valid_o    FIFO head valid
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel_i,
  input  logic [31:0] target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE, // nothing outstanding
    S_WAIT, // granted, awaiting data to keep
    S_DROP  // granted, data belongs to a redirected stream
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic [31:0]        fifo_pc   [FIFO_DEPTH];
  logic [31:0]        fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               fifo_empty;
  logic               fifo_has_room;
  logic               req_fire;
  logic               push;
  logic               pop;

  // The redirect target is word aligned by dropping its low bits.
  logic               unused_target_lsb;
  assign unused_target_lsb = ^target_i[1:0];

  assign fifo_empty    = (count == '0);
  assign fifo_has_room = (count < CNT_W'(FIFO_DEPTH));

  // Gating on room in the FIFO guarantees the single outstanding response
  // always has a free slot when it returns.
  assign imem_req_o  = !rst && !pc_sel_i && (state_q == S_IDLE) && fifo_has_room;
  assign imem_addr_o = fetch_pc;
  assign req_fire    = imem_req_o && imem_gnt_i;

  assign push = (state_q == S_WAIT) && imem_rvalid_i && !pc_sel_i;

  assign inst_valid_o = !rst && !fifo_empty;
  assign pop          = inst_valid_o && !stall_i && !pc_sel_i;

  assign inst_o = inst_valid_o ? fifo_inst[rd_ptr] : 32'h0;
  assign pc_o   = inst_valid_o ? fifo_pc[rd_ptr]   : 32'h0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)  state_d = S_IDLE;
        else if (pc_sel_i)  state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid_i)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, fetch PC, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q <= state_d;

      if (pc_sel_i)
        fetch_pc <= {target_i[31:2], 2'b00};
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;

      if (pc_sel_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage: granted PC tag and FIFO entries, validity tracked above.
  always_ff @(posedge clk) begin
    if (req_fire)
      req_pc <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural
// instruction memory and a PC scoreboard checked on every FIFO pop.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_sel_i;
  logic [31:0] target_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];     // expected PCs in pop order
  logic [31:0] gnt_log[$]; // addresses accepted by memory

  int          rv_delay = 1;
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_i      (pc_sel_i),
    .target_i      (target_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_log(input string tag, input int n,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, 32'(gnt_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < gnt_log.size()) chk($sformatf("%s_%0d", tag, i), gnt_log[i], e[i]);
  endtask

  // Two reset edges; outputs must read zero throughout.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    pc_sel_i = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_req"},   {31'h0, imem_req_o},   32'h0);
    chk({tag, "_rst_vld"},   {31'h0, inst_valid_o}, 32'h0);
    tick(1);
    @(negedge clk);
    chk({tag, "_rst_inst"},  inst_o, 32'h0);
    chk({tag, "_rst_pc"},    pc_o,   32'h0);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'h0);
    tick(1);
    sb.delete();
    gnt_log.delete();
  endtask

  // Memory model: accept on req&gnt, answer rv_delay cycles later.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (pend) begin
        if (pcnt <= 1) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          pcnt--;
        end
      end
      @(negedge clk);
      if (imem_req_o && imem_gnt_i) begin
        pend  = 1'b1;
        pcnt  = rv_delay;
        paddr = imem_addr_o;
        gnt_log.push_back(imem_addr_o);
      end
    end
  end

  // Scoreboard consumer: every pop is compared, every bubble must be zero.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (inst_valid_o) begin
        if (!stall_i && !pc_sel_i) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pop: observed pc %h expected none", pc_o);
          end
          if (sb.size() != 0) begin
            exp_pc = sb.pop_front();
            chk("pop_pc",   pc_o,   exp_pc);
            chk("pop_inst", inst_o, mem_word(exp_pc));
          end
        end
      end else begin
        chk("bubble_inst", inst_o, 32'h0);
        chk("bubble_pc",   pc_o,   32'h0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    pc_sel_i   = 1'b0;
    target_i   = 32'h0;
    stall_i    = 1'b0;
    imem_gnt_i = 1'b1;
    tick(1);

    // Streaming at one instruction every two cycles.
    do_reset("a");
    rst = 1'b0;
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    tick(7);
    chk_log("a_addr", 4, 32'h100, 32'h104, 32'h108, 32'h10C);

    // Fill the FIFO under stall, then drain in order.
    do_reset("b");
    stall_i = 1'b1;
    rst = 1'b0;
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    tick(4);
    @(negedge clk);
    chk("b_full_req",  {31'h0, imem_req_o}, 32'h0);
    chk("b_hold_pc",   pc_o,   32'h100);
    chk("b_hold_inst", inst_o, mem_word(32'h100));
    tick(1);
    @(negedge clk);
    chk("b_full_req2", {31'h0, imem_req_o}, 32'h0);
    chk("b_hold_pc2",  pc_o,   32'h100);
    tick(1);
    stall_i = 1'b0;
    tick(2);
    chk_log("b_addr", 3, 32'h100, 32'h104, 32'h108, 32'h0);

    // Redirect while waiting: response dropped, restart at aligned target.
    rv_delay = 2;
    do_reset("c");
    rst = 1'b0;
    sb.push_back(32'h100);
    sb.push_back(32'h200);
    tick(4);
    pc_sel_i = 1'b1;
    target_i = 32'h0000_0203;
    @(negedge clk);
    chk("c_redir_req", {31'h0, imem_req_o}, 32'h0);
    tick(1);
    pc_sel_i = 1'b0;
    @(negedge clk);
    chk("c_flush_vld", {31'h0, inst_valid_o}, 32'h0);
    tick(1);
    @(negedge clk);
    chk("c_new_req",  {31'h0, imem_req_o}, 32'h1);
    chk("c_new_addr", imem_addr_o, 32'h200);
    tick(4);
    chk_log("c_addr", 4, 32'h100, 32'h104, 32'h200, 32'h204);

    // Grant held off, then redirect with rvalid, then address wrap.
    rv_delay = 1;
    imem_gnt_i = 1'b0;
    do_reset("d");
    rst = 1'b0;
    sb.push_back(32'h100);
    sb.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("d_hold_req_%0d", i),  {31'h0, imem_req_o}, 32'h1);
      chk($sformatf("d_hold_addr_%0d", i), imem_addr_o, 32'h100);
      tick(1);
    end
    imem_gnt_i = 1'b1;
    tick(3);
    pc_sel_i = 1'b1;
    target_i = 32'hFFFF_FFFF;
    tick(1);
    pc_sel_i = 1'b0;
    @(negedge clk);
    chk("d_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick(2);
    @(negedge clk);
    chk("d_wrap_req",  {31'h0, imem_req_o}, 32'h1);
    chk("d_wrap_addr", imem_addr_o, 32'h0);
    tick(1);
    chk_log("d_addr", 4, 32'h100, 32'h104, 32'hFFFF_FFFC, 32'h0);

    // Reset during WAIT; the late response must be ignored.
    rv_delay = 3;
    do_reset("e");
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    imem_gnt_i = 1'b0;
    @(negedge clk);
    chk("e_rst_req",  {31'h0, imem_req_o},   32'h0);
    chk("e_rst_vld",  {31'h0, inst_valid_o}, 32'h0);
    chk("e_rst_inst", inst_o, 32'h0);
    chk("e_rst_pc",   pc_o,   32'h0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("e_req",  {31'h0, imem_req_o}, 32'h1);
    chk("e_addr", imem_addr_o, 32'h100);
    tick(2);
    rv_delay = 1;
    imem_gnt_i = 1'b1;
    sb.push_back(32'h100);
    @(negedge clk);
    chk("e_late_ignored", {31'h0, inst_valid_o}, 32'h0);
    tick(4);
    chk("e_sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
